inst_fetch_unit: RTL

//   Requester side of the instruction-memory interface: owns the program counter, drives

---
 rtl/rv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/inst_fetch_unit.sv | 76 +++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   XLEN             : address / instruction width
//   RV_NOP           : canonical RISC-V NOP (addi x0, x0, 0)
//   RESET_PC_DEFAULT : default program counter after reset
//   fetch_entry_t    : one buffered fetch, {pc, instr}
package rv_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RV_NOP           = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : drop all entries and zero both pointers (wins over push/pop)
//   push, wdata  : write wdata at the tail
//   pop          : retire the head entry
//   rdata        : head entry (meaningful only while count != 0)
//   count        : number of valid entries, 0..DEPTH
// The caller guarantees that push is only raised when not full or when popping,
// and that pop is only raised when count != 0.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2 * XLEN
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset: entries are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses a combinational instruction
// memory, buffers {pc, instr} pairs and hands them to decode via valid/ready.
// A redirect flushes the buffer and reloads the PC.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   imem_addr          : instruction memory address (the pc register)
//   imem_rdata         : instruction word for imem_addr, same cycle
//   redirect_valid/pc  : branch/jump redirect pulse and target
//   if_valid/if_ready  : decode handshake on the buffer head
//   if_instr/if_pc     : head instruction and its PC, zero while !if_valid
//   if_count           : buffered entries
module inst_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN       = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter logic [XLEN-1:0] PC_INCR    = XLEN'(1),
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  output logic [XLEN-1:0]               imem_addr,
  input  logic [XLEN-1:0]               imem_rdata,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          if_valid,
  input  logic                          if_ready,
  output logic [XLEN-1:0]               if_instr,
  output logic [XLEN-1:0]               if_pc,
  output logic [$clog2(FIFO_DEPTH):0]   if_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0]   pc;
  logic              pop;
  logic              push;
  logic              full;
  logic [2*XLEN-1:0] head;

  assign full     = (if_count == CW'(FIFO_DEPTH));
  assign if_valid = (if_count != '0);
  assign pop      = if_valid && if_ready;
  // A pop frees a slot in the same edge, so a full buffer can still accept.
  assign push     = !redirect_valid && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc + PC_INCR;
    end
  end

  assign imem_addr = pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (redirect_valid),
    .push    (push),
    .pop     (pop),
    .wdata   ({pc, imem_rdata}),
    .rdata   (head),
    .count   (if_count)
  );

  assign if_pc    = if_valid ? head[2*XLEN-1:XLEN] : '0;
  assign if_instr = if_valid ? head[XLEN-1:0]      : '0;

endmodule
